// File: rtl/id_ex_aludec_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_aludec_pkg
// Shared constants for the ID->EX ALU decode slice: ALU operation codes
// (also consumed by the ALU itself) and the RV32 opcode / funct fields the
// decoder recognises. The helper maps a base-ISA funct3 onto its ALU code.
// ---------------------------------------------------------------------------
package id_ex_aludec_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_DIV  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_ADD  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hD;
  localparam logic [3:0] ALU_SRL  = 4'hE;

  // RV32 major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct7 variants
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;

  // funct3 -> ALU code for the base (funct7 = 0) integer operations
  function automatic logic [3:0] base_alu_code(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      F3_ADD:  code = ALU_ADD;
      F3_SLL:  code = ALU_SLL;
      F3_SLT:  code = ALU_SLT;
      F3_SLTU: code = ALU_SLTU;
      F3_XOR:  code = ALU_XOR;
      F3_SRL:  code = ALU_SRL;
      F3_OR:   code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/id_ex_aludec_alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Purely combinational RV32 ALU decoder: instruction word plus register-file
// operands in, one decoded ALU entry out.
//   instr_i     RV32 instruction word
//   rs1_i/rs2_i register-file read data
//   op1_o/op2_o ALU operands (zero when illegal)
//   aluop_o     ALU operation code (NOP when illegal)
//   rd_o        destination register (instr[11:7])
//   we_o        writeback enable (legal and rd != 0)
//   illegal_o   encoding not recognised
// ---------------------------------------------------------------------------
module alu_decode
  import id_ex_aludec_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ALUOP = 4
) (
  input  logic [31:0]      instr_i,
  input  logic [WORD-1:0]  rs1_i,
  input  logic [WORD-1:0]  rs2_i,
  output logic [WORD-1:0]  op1_o,
  output logic [WORD-1:0]  op2_o,
  output logic [ALUOP-1:0] aluop_o,
  output logic [4:0]       rd_o,
  output logic             we_o,
  output logic             illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic signed [11:0] imm_i;
  logic [WORD-1:0]   imm_sx;
  logic [WORD-1:0]   shamt_zx;
  logic [WORD-1:0]   upper_imm;
  logic [3:0]        code;
  logic              legal;
  logic [WORD-1:0]   op1;
  logic [WORD-1:0]   op2;

  assign opcode    = instr_i[6:0];
  assign f3        = instr_i[14:12];
  assign f7        = instr_i[31:25];
  assign imm_i     = instr_i[31:20];
  // Size cast of a signed value sign-extends to WORD.
  assign imm_sx    = WORD'(imm_i);
  assign shamt_zx  = WORD'(instr_i[24:20]);
  assign upper_imm = WORD'({instr_i[31:12], 12'b0});

  always_comb begin
    code  = ALU_NOP;
    legal = 1'b0;
    op1   = rs1_i;
    op2   = rs2_i;
    case (opcode)
      OPC_OP: begin
        case (f7)
          F7_BASE: begin
            legal = 1'b1;
            code  = base_alu_code(f3);
          end
          F7_ALT: begin
            if (f3 == F3_ADD) begin
              legal = 1'b1;
              code  = ALU_SUB;
            end else if (f3 == F3_SRL) begin
              legal = 1'b1;
              code  = ALU_SRA;
            end
          end
          F7_MULDIV: begin
            if (f3 == F3_MUL) begin
              legal = 1'b1;
              code  = ALU_MUL;
            end else if (f3 == F3_DIV) begin
              legal = 1'b1;
              code  = ALU_DIV;
            end
          end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        op2 = imm_sx;
        case (f3)
          // Shift-immediates reuse imm[11:5] as funct7 and take a 5-bit shamt.
          F3_SLL: begin
            op2 = shamt_zx;
            if (f7 == F7_BASE) begin
              legal = 1'b1;
              code  = ALU_SLL;
            end
          end
          F3_SRL: begin
            op2 = shamt_zx;
            if (f7 == F7_BASE) begin
              legal = 1'b1;
              code  = ALU_SRL;
            end else if (f7 == F7_ALT) begin
              legal = 1'b1;
              code  = ALU_SRA;
            end
          end
          default: begin
            legal = 1'b1;
            code  = base_alu_code(f3);
          end
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        code  = ALU_ADD;
        op1   = '0;
        op2   = upper_imm;
      end
      default: ;
    endcase
    if (!legal) begin
      code = ALU_NOP;
      op1  = '0;
      op2  = '0;
    end
  end

  assign op1_o     = op1;
  assign op2_o     = op2;
  assign aluop_o   = ALUOP'(code);
  assign rd_o      = instr_i[11:7];
  assign we_o      = legal && (instr_i[11:7] != 5'd0);
  assign illegal_o = !legal;

endmodule

// File: rtl/id_ex_aludec.sv
// ---------------------------------------------------------------------------
// id_ex_aludec
// ID->EX boundary: decodes the incoming instruction combinationally and
// buffers decoded entries in a 2-entry in-order FIFO toward the ALU.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   id_valid_i / id_ready_o      upstream handshake
//   id_instr_i, id_datars*_i     instruction and register operands
//   flush_i                      drop all buffered and same-cycle entries
//   ex_valid_o / ex_ready_i      downstream handshake
//   ex_datars*_o, ex_aluop_o,
//   ex_rd_o, ex_we_o, ex_illegal_o  head entry of the FIFO
// ---------------------------------------------------------------------------
module id_ex_aludec
  import id_ex_aludec_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ALUOP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [31:0]      id_instr_i,
  input  logic [WORD-1:0]  id_datars1_i,
  input  logic [WORD-1:0]  id_datars2_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [WORD-1:0]  ex_datars1_o,
  output logic [WORD-1:0]  ex_datars2_o,
  output logic [ALUOP-1:0] ex_aluop_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_we_o,
  output logic             ex_illegal_o
);

  logic [WORD-1:0]  dec_op1;
  logic [WORD-1:0]  dec_op2;
  logic [ALUOP-1:0] dec_aluop;
  logic [4:0]       dec_rd;
  logic             dec_we;
  logic             dec_illegal;

  alu_decode #(
    .WORD  (WORD),
    .ALUOP (ALUOP)
  ) u_alu_decode (
    .instr_i   (id_instr_i),
    .rs1_i     (id_datars1_i),
    .rs2_i     (id_datars2_i),
    .op1_o     (dec_op1),
    .op2_o     (dec_op2),
    .aluop_o   (dec_aluop),
    .rd_o      (dec_rd),
    .we_o      (dec_we),
    .illegal_o (dec_illegal)
  );

  logic [1:0]       count_q,   count_d;
  logic             wr_ptr_q,  wr_ptr_d;
  logic             rd_ptr_q,  rd_ptr_d;
  logic [WORD-1:0]  op1_q[2],  op1_d[2];
  logic [WORD-1:0]  op2_q[2],  op2_d[2];
  logic [ALUOP-1:0] aluop_q[2], aluop_d[2];
  logic [4:0]       rd_q[2],   rd_d[2];
  logic             we_q[2],   we_d[2];
  logic             ill_q[2],  ill_d[2];

  logic push;
  logic pop;

  // Handshake depends on registered count only, so ready has no comb path
  // from any input.
  assign id_ready_o = (count_q != 2'd2);
  assign ex_valid_o = (count_q != 2'd0);
  assign push       = id_valid_i && id_ready_o && !flush_i;
  assign pop        = ex_valid_o && ex_ready_i && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    aluop_d  = aluop_q;
    rd_d     = rd_q;
    we_d     = we_q;
    ill_d    = ill_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        op1_d[wr_ptr_q]   = dec_op1;
        op2_d[wr_ptr_q]   = dec_op2;
        aluop_d[wr_ptr_q] = dec_aluop;
        rd_d[wr_ptr_q]    = dec_rd;
        we_d[wr_ptr_q]    = dec_we;
        ill_d[wr_ptr_q]   = dec_illegal;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is cleared on reset too so the head reads as all zeros afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      op1_q    <= '{default: '0};
      op2_q    <= '{default: '0};
      aluop_q  <= '{default: '0};
      rd_q     <= '{default: '0};
      we_q     <= '{default: 1'b0};
      ill_q    <= '{default: 1'b0};
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      aluop_q  <= aluop_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      ill_q    <= ill_d;
    end
  end

  assign ex_datars1_o = op1_q[rd_ptr_q];
  assign ex_datars2_o = op2_q[rd_ptr_q];
  assign ex_aluop_o   = aluop_q[rd_ptr_q];
  assign ex_rd_o      = rd_q[rd_ptr_q];
  assign ex_we_o      = we_q[rd_ptr_q];
  assign ex_illegal_o = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_id_ex_aludec.sv
// ---------------------------------------------------------------------------
// tb_id_ex_aludec
// Bench for id_ex_aludec: directed vector table, hand-written handshake /
// flush / reset sequences, and randomized traffic against a queue model with
// a pattern-table instruction decoder.
// ---------------------------------------------------------------------------
module tb_id_ex_aludec;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs1;
  logic [31:0] id_rs2;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_illegal;

  always #5 clk = ~clk;

  id_ex_aludec #(.WORD(32), .ALUOP(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_ready_o   (id_ready),
    .id_instr_i   (id_instr),
    .id_datars1_i (id_rs1),
    .id_datars2_i (id_rs2),
    .flush_i      (flush),
    .ex_valid_o   (ex_valid),
    .ex_ready_i   (ex_ready),
    .ex_datars1_o (ex_rs1),
    .ex_datars2_o (ex_rs2),
    .ex_aluop_o   (ex_aluop),
    .ex_rd_o      (ex_rd),
    .ex_we_o      (ex_we),
    .ex_illegal_o (ex_illegal)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    ent_t        exp;
  } vec_t;

  // Legal-encoding table: kind 0 reg/reg, 1 I-imm, 2 shamt, 3 LUI
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    bit         f3_any;
    logic [6:0] f7;
    bit         f7_any;
    logic [3:0] code;
    int         kind;
  } pat_t;

  pat_t pats[$];
  int   nchecks = 0;
  int   nerrors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input ent_t e);
    chk({tag, ".valid"},   64'(ex_valid),   64'd1);
    chk({tag, ".d1"},      64'(ex_rs1),     64'(e.d1));
    chk({tag, ".d2"},      64'(ex_rs2),     64'(e.d2));
    chk({tag, ".aluop"},   64'(ex_aluop),   64'(e.aluop));
    chk({tag, ".rd"},      64'(ex_rd),      64'(e.rd));
    chk({tag, ".we"},      64'(ex_we),      64'(e.we));
    chk({tag, ".illegal"}, 64'(ex_illegal), 64'(e.ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_pat(input logic [6:0] opc, input logic [2:0] f3, input bit f3_any,
                                  input logic [6:0] f7, input bit f7_any,
                                  input logic [3:0] code, input int kind);
    pat_t p;
    p.opc = opc; p.f3 = f3; p.f3_any = f3_any; p.f7 = f7; p.f7_any = f7_any;
    p.code = code; p.kind = kind;
    pats.push_back(p);
  endfunction

  function automatic ent_t ref_decode(input logic [31:0] instr, input logic [31:0] rs1,
                                      input logic [31:0] rs2);
    ent_t e;
    e.d1 = 32'd0; e.d2 = 32'd0; e.aluop = 4'h0; e.rd = instr[11:7]; e.we = 1'b0; e.ill = 1'b1;
    foreach (pats[i]) begin
      if (e.ill && pats[i].opc == instr[6:0] &&
          (pats[i].f3_any || pats[i].f3 == instr[14:12]) &&
          (pats[i].f7_any || pats[i].f7 == instr[31:25])) begin
        e.ill   = 1'b0;
        e.aluop = pats[i].code;
        e.we    = (instr[11:7] != 5'd0);
        e.d1    = (pats[i].kind == 3) ? 32'd0 : rs1;
        case (pats[i].kind)
          0:       e.d2 = rs2;
          1:       e.d2 = {{20{instr[31]}}, instr[31:20]};
          2:       e.d2 = {27'd0, instr[24:20]};
          default: e.d2 = {instr[31:12], 12'd0};
        endcase
      end
    end
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op,
                              input logic [4:0] rd, input logic we, input logic ill);
    ent_t e;
    e.d1 = d1; e.d2 = d2; e.aluop = op; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'b0000000;
          1: w[31:25] = 7'b0100000;
          2: w[31:25] = 7'b0000001;
          default: ;
        endcase
      end
      1: begin
        w[6:0] = 7'b0010011;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'b0000000;
          1: w[31:25] = 7'b0100000;
          default: ;
        endcase
      end
      2: w[6:0] = 7'b0110111;
      3: w[6:0] = 7'b0010011;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  vec_t vecs[$];
  ent_t model_q[$];

  initial begin
    ent_t zero_e;
    ent_t ea;
    vec_t v;

    // OP
    add_pat(7'b0110011, 3'b000, 0, 7'h00, 0, 4'h8, 0);
    add_pat(7'b0110011, 3'b001, 0, 7'h00, 0, 4'h7, 0);
    add_pat(7'b0110011, 3'b010, 0, 7'h00, 0, 4'h9, 0);
    add_pat(7'b0110011, 3'b011, 0, 7'h00, 0, 4'hA, 0);
    add_pat(7'b0110011, 3'b100, 0, 7'h00, 0, 4'h5, 0);
    add_pat(7'b0110011, 3'b101, 0, 7'h00, 0, 4'hE, 0);
    add_pat(7'b0110011, 3'b110, 0, 7'h00, 0, 4'h6, 0);
    add_pat(7'b0110011, 3'b111, 0, 7'h00, 0, 4'h4, 0);
    add_pat(7'b0110011, 3'b000, 0, 7'h20, 0, 4'h1, 0);
    add_pat(7'b0110011, 3'b101, 0, 7'h20, 0, 4'hD, 0);
    add_pat(7'b0110011, 3'b000, 0, 7'h01, 0, 4'h2, 0);
    add_pat(7'b0110011, 3'b100, 0, 7'h01, 0, 4'h3, 0);
    // OP-IMM
    add_pat(7'b0010011, 3'b000, 0, 7'h00, 1, 4'h8, 1);
    add_pat(7'b0010011, 3'b010, 0, 7'h00, 1, 4'h9, 1);
    add_pat(7'b0010011, 3'b011, 0, 7'h00, 1, 4'hA, 1);
    add_pat(7'b0010011, 3'b100, 0, 7'h00, 1, 4'h5, 1);
    add_pat(7'b0010011, 3'b110, 0, 7'h00, 1, 4'h6, 1);
    add_pat(7'b0010011, 3'b111, 0, 7'h00, 1, 4'h4, 1);
    add_pat(7'b0010011, 3'b001, 0, 7'h00, 0, 4'h7, 2);
    add_pat(7'b0010011, 3'b101, 0, 7'h00, 0, 4'hE, 2);
    add_pat(7'b0010011, 3'b101, 0, 7'h20, 0, 4'hD, 2);
    // LUI
    add_pat(7'b0110111, 3'b000, 1, 7'h00, 1, 4'h8, 3);

    // Directed vectors: {instr, rs1, rs2, expected head}
    v = '{32'h002081B3, 32'd10, 32'd5, mk(32'd10, 32'd5, 4'h8, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h402081B3, 32'd10, 32'd5, mk(32'd10, 32'd5, 4'h1, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h022081B3, 32'd10, 32'd5, mk(32'd10, 32'd5, 4'h2, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h4010D193, 32'hFFFFFFF8, 32'd5, mk(32'hFFFFFFF8, 32'd1, 4'hD, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'hFFF08193, 32'd7, 32'd5, mk(32'd7, 32'hFFFFFFFF, 4'h8, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h00000000, 32'd7, 32'd5, mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b1)}; vecs.push_back(v);
    v = '{32'h123450B7, 32'd7, 32'd5, mk(32'd0, 32'h12345000, 4'h8, 5'd1, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h0020F033, 32'd9, 32'd6, mk(32'd9, 32'd6, 4'h4, 5'd0, 1'b0, 1'b0)}; vecs.push_back(v);
    v = '{32'h40109193, 32'd9, 32'd6, mk(32'd0, 32'd0, 4'h0, 5'd3, 1'b0, 1'b1)}; vecs.push_back(v);
    v = '{32'h0220C1B3, 32'd9, 32'd6, mk(32'd9, 32'd6, 4'h3, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h0050B193, 32'd9, 32'd6, mk(32'd9, 32'd5, 4'hA, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);
    v = '{32'h0030D193, 32'd9, 32'd6, mk(32'd9, 32'd3, 4'hE, 5'd3, 1'b1, 1'b0)}; vecs.push_back(v);

    zero_e = mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0);

    rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; id_rs1 = 32'd0; id_rs2 = 32'd0;
    flush = 1'b0; ex_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("reset.ex_valid", 64'(ex_valid), 64'd0);
    chk("reset.id_ready", 64'(id_ready), 64'd1);
    chk("reset.d1", 64'(ex_rs1), 64'd0);
    chk("reset.d2", 64'(ex_rs2), 64'd0);
    chk("reset.aluop", 64'(ex_aluop), 64'd0);
    chk("reset.rd", 64'(ex_rd), 64'd0);
    chk("reset.we", 64'(ex_we), 64'd0);
    chk("reset.illegal", 64'(ex_illegal), 64'd0);

    // Vector table: single transfer into empty FIFO, visible right after the edge
    foreach (vecs[i]) begin
      id_valid = 1'b1; id_instr = vecs[i].instr; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      ex_ready = 1'b0;
      step();
      id_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i].exp);
      ex_ready = 1'b1;
      step();
      ex_ready = 1'b0;
      chk($sformatf("vec%0d.drained", i), 64'(ex_valid), 64'd0);
    end

    // Backpressure: three back-to-back pushes with EX stalled
    ex_ready = 1'b0; id_valid = 1'b1; id_instr = 32'h002081B3; id_rs2 = 32'd1;
    id_rs1 = 32'h100; step();
    id_rs1 = 32'h200; step();
    chk("bp.full_ready", 64'(id_ready), 64'd0);
    id_rs1 = 32'h300; step();
    chk("bp.held_ready", 64'(id_ready), 64'd0);
    ea = mk(32'h100, 32'd1, 4'h8, 5'd3, 1'b1, 1'b0);
    chk_head("bp.head_a_stall", ea);
    ex_ready = 1'b1; step();
    ea.d1 = 32'h200; chk_head("bp.head_b", ea);
    chk("bp.ready_after_pop", 64'(id_ready), 64'd1);
    step();
    ea.d1 = 32'h300; chk_head("bp.head_c", ea);
    id_valid = 1'b0; step();
    chk("bp.empty", 64'(ex_valid), 64'd0);
    ex_ready = 1'b0;

    // Flush with FIFO full and a same-cycle push
    id_valid = 1'b1; id_rs1 = 32'h11; step(); id_rs1 = 32'h22; step();
    chk("flush.full", 64'(id_ready), 64'd0);
    flush = 1'b1; id_rs1 = 32'h33; ex_ready = 1'b1; step();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush.ex_valid", 64'(ex_valid), 64'd0);
    chk("flush.id_ready", 64'(id_ready), 64'd1);
    step();
    chk("flush.dropped", 64'(ex_valid), 64'd0);
    ex_ready = 1'b0;

    // Reset mid-stream discards buffered entries
    id_valid = 1'b1; id_rs1 = 32'h44; step(); id_rs1 = 32'h55; step();
    id_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("midrst.ex_valid", 64'(ex_valid), 64'd0);
    chk("midrst.d1", 64'(ex_rs1), 64'd0);
    chk("midrst.we", 64'(ex_we), 64'd0);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("midrst.nopulse%0d", k), 64'(ex_valid), 64'd0);
    end
    chk("midrst.aluop_zero", 64'(ex_aluop), 64'(zero_e.aluop));

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      ent_t exp_e;
      bit   acc;
      bit   rel;
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      id_instr = gen_instr();
      id_rs1   = $urandom;
      id_rs2   = $urandom;
      exp_e    = ref_decode(id_instr, id_rs1, id_rs2);
      acc      = id_valid && (model_q.size() < 2) && !flush;
      rel      = (model_q.size() > 0) && ex_ready && !flush;
      step();
      if (flush) model_q.delete();
      else begin
        if (rel) void'(model_q.pop_front());
        if (acc) model_q.push_back(exp_e);
      end
      chk("rnd.ex_valid", 64'(ex_valid), 64'(model_q.size() != 0));
      chk("rnd.id_ready", 64'(id_ready), 64'(model_q.size() != 2));
      if (model_q.size() != 0) chk_head($sformatf("rnd%0d", n), model_q[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
